fb_write_queue: RTL

FB_WRITE_QUEUE -- requirements
Module: fb_write_queue

---
 rtl/fb_write_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fb_write_queue.sv
// Rasterizer pixel write queue: range-checks pixels, converts them to framebuffer word
// addresses, buffers them in a small FIFO and issues single writes, plus a full-frame clear.
// The adapter stall input is named wait_req because "wait" is a reserved word.
module fb_write_queue #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter logic [25:0] FB_BASE = 26'h0,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic [31:0] pix_color,
  input  logic        clear_start,
  input  logic [31:0] clear_color,
  output logic        busy,
  output logic [15:0] drop_cnt,
  output logic        write,
  output logic        read,
  output logic [31:0] write_data,
  output logic [25:0] address,
  input  logic        wait_req
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] CLR_LAST = 32'(H_RES * V_RES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, CLEAR_ISSUE, CLEAR_GAP} state_t;

  state_t        state, state_n;
  logic [25:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          clear_pend, pend_n;
  logic [31:0]   pend_color, pend_color_n;
  logic [31:0]   clr_idx, clr_idx_n;
  logic          write_n;
  logic [25:0]   addr_n;
  logic [31:0]   data_n;

  logic          in_range, accept, push, drop, pop, clearing;
  logic [25:0]   lin, pix_addr;

  assign clearing  = (state == CLEAR_ISSUE) || (state == CLEAR_GAP);
  assign pix_ready = (count < CW'(DEPTH)) && !clear_pend && !clearing;
  assign in_range  = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
  assign accept    = pix_valid && pix_ready;
  assign push      = accept && in_range;
  assign drop      = accept && !in_range;
  assign lin       = 26'(pix_y) * 26'(H_RES) + 26'(pix_x);
  assign pix_addr  = FB_BASE + {lin[24:0], 1'b0};
  assign busy      = (count != '0) || (state != IDLE) || clear_pend;
  assign read      = 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= pix_addr;
      fifo_data[wr_ptr] <= pix_color;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      write      <= 1'b0;
      address    <= '0;
      write_data <= '0;
      clr_idx    <= '0;
      clear_pend <= 1'b0;
      pend_color <= '0;
    end else begin
      state      <= state_n;
      write      <= write_n;
      address    <= addr_n;
      write_data <= data_n;
      clr_idx    <= clr_idx_n;
      clear_pend <= pend_n;
      pend_color <= pend_color_n;
    end
  end

  always_comb begin
    state_n      = state;
    write_n      = write;
    addr_n       = address;
    data_n       = write_data;
    clr_idx_n    = clr_idx;
    pend_n       = clear_pend;
    pend_color_n = pend_color;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        // A clear starts only once nothing is queued or being queued this cycle
        if ((clear_pend || clear_start) && count == '0 && !push) begin
          state_n   = CLEAR_ISSUE;
          write_n   = 1'b1;
          addr_n    = FB_BASE;
          data_n    = clear_pend ? pend_color : clear_color;
          clr_idx_n = '0;
          pend_n    = 1'b0;
        end else if (count != '0) begin
          state_n = ISSUE;
          write_n = 1'b1;
          addr_n  = fifo_addr[rd_ptr];
          data_n  = fifo_data[rd_ptr];
        end
      end
      ISSUE: begin
        if (!wait_req) begin
          pop     = 1'b1;
          state_n = GAP;
          write_n = 1'b0;
        end
      end
      GAP: begin
        if (count != '0) begin
          state_n = ISSUE;
          write_n = 1'b1;
          addr_n  = fifo_addr[rd_ptr];
          data_n  = fifo_data[rd_ptr];
        end else begin
          state_n = IDLE;
        end
      end
      CLEAR_ISSUE: begin
        if (!wait_req) begin
          write_n = 1'b0;
          if (clr_idx == CLR_LAST) begin
            state_n = IDLE;
          end else begin
            state_n   = CLEAR_GAP;
            clr_idx_n = clr_idx + 1'b1;
          end
        end
      end
      CLEAR_GAP: begin
        state_n = CLEAR_ISSUE;
        write_n = 1'b1;
        addr_n  = address + 26'd2;
      end
      default: begin
        state_n = IDLE;
        write_n = 1'b0;
      end
    endcase
    // Deferred clear: remember the request and its color until the queue drains
    if (clear_start && !clear_pend && !clearing && state_n != CLEAR_ISSUE) begin
      pend_n       = 1'b1;
      pend_color_n = clear_color;
    end
  end

endmodule
